axis_fifo_alternate: RTL and testbench
======================================

# axis_fifo_alternate

Synchronous single-clock AXI4-Stream FIFO that buffers `mem_depth` beats of data, tkeep and tlast between an upstream source and a downstream sink. The slave side has no back-pressure (no `s_axis_tready`). Beats offered while the FIFO is full are discarded. The master side is first-word-fall-through with a standard valid/ready handshake.

## Interface
Parameters:
- `data_bits`, default 8: width of tdata in bits; multiple of 8.
- `mem_depth`, default 16: number of storage entries; power of two, ≥ 2.
- `tkeep_width`, default `data_bits/8`: width of tkeep.

Ports:
- `axis_clk` in 1: single clock; all state changes on the rising edge.
- `axis_resetn` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in `data_bits`: input beat data.
- `s_axis_tkeep` in `tkeep_width`: input byte qualifiers, stored verbatim.
- `s_axis_tlast` in 1: input end-of-packet, stored verbatim.
- `s_axis_tvalid` in 1: input beat offered this cycle.
- `m_axis_tdata` out `data_bits`: head-of-FIFO data.
- `m_axis_tkeep` out `tkeep_width`: head-of-FIFO tkeep.
- `m_axis_tlast` out 1: head-of-FIFO tlast.
- `m_axis_tvalid` out 1: FIFO non-empty.
- `m_axis_tready` in 1: sink accepts head beat.

## Operation
- Storage: circular buffer of `mem_depth` entries, each entry `{tlast, tkeep, tdata}`. Memory contents are not reset.
- Pointers: write pointer and read pointer, each `log2(mem_depth)+1` bits. The low bits index the memory and the MSB is a wrap flag.
  - empty: pointers are equal.
  - full: low bits are equal and MSBs differ.
  - occupancy = wr_ptr − rd_ptr (modulo 2·`mem_depth`), range 0..`mem_depth`.
- Read (pop): occurs when `m_axis_tvalid && m_axis_tready`. rd_ptr increments by 1 and wraps naturally.
- Write (push): occurs when `s_axis_tvalid` is high and either the FIFO is not full, or it is full and a pop occurs in the same cycle. The entry at wr_ptr is written and wr_ptr increments by 1.
- Overflow: when the FIFO is full and no pop occurs, an `s_axis_tvalid` beat is silently dropped. No pointer or memory change occurs, and no error flag is raised.
- Master outputs:
  - `m_axis_tvalid` = not empty.
  - When non-empty, `m_axis_tdata`/`m_axis_tkeep`/`m_axis_tlast` show the entry at rd_ptr (combinational read of registered storage).
  - When empty, these outputs are driven to 0.
- Ordering: strict FIFO; beats are never reordered or duplicated.
- `s_axis_tkeep` and `s_axis_tlast` have no effect on control; they are carried through only.

## Timing
- Reset (asynchronous assert, synchronous release): both pointers go to 0. Consequently `m_axis_tvalid`=0 and `m_axis_tdata`/`m_axis_tkeep`/`m_axis_tlast`=0 immediately on assertion. `s_axis_tvalid` is ignored while reset is held.
- Reset mid-operation: all buffered beats are lost and the FIFO reads empty.
- Write-to-output latency: a beat pushed at edge k is visible, with `m_axis_tvalid`=1, right after edge k when the FIFO was empty.
- Pop: the head beat is consumed at the edge where tvalid and tready are both high. The next entry (or the empty state) appears after that edge.
- Simultaneous push and pop:
  - When the FIFO is neither empty nor full, occupancy is unchanged.
  - When the FIFO is empty, only the push takes effect (nothing to pop).
  - When the FIFO is full, both take effect and it stays full.
- `m_axis_tready` while empty has no effect.
- No combinational path from `s_axis_*` to `m_axis_*`. `m_axis_*` depends only on registers plus reset.

## Test plan
- Reset: hold `axis_resetn`=0 for 5 cycles with `s_axis_tvalid`=1 → `m_axis_tvalid`=0, `m_axis_tdata`=0x00, `m_axis_tkeep`=0, `m_axis_tlast`=0; nothing is stored after release.
- Fill and overflow: `m_axis_tready`=0 and 20 consecutive beats `s_axis_tdata`=D0..D19 with tkeep=1, tlast=0.
  - `m_axis_tvalid` rises after the first edge and `m_axis_tdata`=D0.
  - The FIFO holds D0..D15; D16..D19 are dropped.
- Drain: after the fill, `s_axis_tvalid`=0 and `m_axis_tready`=1 for 20 cycles.
  - Exactly 16 beats D0..D15 are delivered in order, one per cycle.
  - `m_axis_tvalid` falls after the 16th pop and the outputs return to 0.
- Streaming: `m_axis_tready`=1 and continuous writes of 0x01,0x02,0x03… → each beat appears one edge after it is written. Occupancy stays ≤1 and no beat is lost.
- Full with simultaneous push and pop: fill 16 beats, then in one cycle `s_axis_tvalid`=1 with data 0xAA and `m_axis_tready`=1 → the head beat pops, 0xAA is accepted, and the FIFO stays full. 0xAA emerges as the 16th subsequent beat.
- Sideband and wrap: write 40 beats with alternating tlast=1/0 and tkeep patterns while draining at half rate → tkeep/tlast follow their data through pointer wrap-around, in order.

Source files
------------

// File: rtl/axis_fifo_alternate.sv
// axis_fifo_alternate
// Single-clock AXI4-Stream FIFO with first-word-fall-through output.
// The slave side has no back-pressure: beats offered while the FIFO is full
// (and no pop happens in the same cycle) are silently dropped.
// Each entry stores {tlast, tkeep, tdata}; sideband bits are carried verbatim.

module axis_fifo_alternate #(
    parameter int data_bits   = 8,
    parameter int mem_depth   = 16,
    parameter int tkeep_width = data_bits / 8
) (
    input  logic                   axis_clk,
    input  logic                   axis_resetn,
    input  logic [data_bits-1:0]   s_axis_tdata,
    input  logic [tkeep_width-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic [data_bits-1:0]   m_axis_tdata,
    output logic [tkeep_width-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready
);

    localparam int addr_bits  = $clog2(mem_depth);
    localparam int entry_bits = 1 + tkeep_width + data_bits;
    localparam logic [addr_bits:0] ptr_one = (addr_bits + 1)'(1);

    // Storage is never reset; only the pointers define what is valid.
    logic [entry_bits-1:0] mem [mem_depth];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [addr_bits:0] wr_ptr;
    logic [addr_bits:0] rd_ptr;

    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic [entry_bits-1:0] wr_entry;
    logic [entry_bits-1:0] head_entry;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[addr_bits-1:0] == rd_ptr[addr_bits-1:0]) &&
                   (wr_ptr[addr_bits] != rd_ptr[addr_bits]);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a beat.
    assign pop  = !empty && m_axis_tready;
    assign push = s_axis_tvalid && (!full || pop);

    assign wr_entry   = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    assign head_entry = mem[rd_ptr[addr_bits-1:0]];

    // Pointer update; reset empties the FIFO immediately.
    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_one;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_one;
            end
        end
    end

    // Memory write; gated by reset so nothing lands while reset is held.
    always_ff @(posedge axis_clk) begin
        if (push && axis_resetn) begin
            mem[wr_ptr[addr_bits-1:0]] <= wr_entry;
        end
    end

    // Head-of-FIFO view, forced to zero while empty.
    always_comb begin
        m_axis_tvalid = !empty;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        if (!empty) begin
            m_axis_tdata = head_entry[data_bits-1:0];
            m_axis_tkeep = head_entry[data_bits +: tkeep_width];
            m_axis_tlast = head_entry[entry_bits-1];
        end
    end

endmodule

// File: tb/tb_axis_fifo_alternate.sv
// Bench for axis_fifo_alternate: a queue-based model of the FIFO rules is
// checked against the DUT every negative clock edge, plus directed literal
// expectations for each scenario.

module tb_axis_fifo_alternate;

    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int KW    = DB / 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic [DB-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic [DB-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: entries {tlast, tkeep, tdata}, head at index 0.
    logic [DB+KW:0] q[$];
    // Beats seen leaving the DUT (captured when valid&&ready before the edge).
    logic [DB+KW:0] log_q[$];

    axis_fifo_alternate #(
        .data_bits  (DB),
        .mem_depth  (DEPTH),
        .tkeep_width(KW)
    ) dut (
        .axis_clk     (clk),
        .axis_resetn  (resetn),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tlast (s_tlast),
        .s_axis_tvalid(s_tvalid),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tlast (m_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DB-1:0] fill_d(input int i);
        return DB'(8'h30 + 3 * i);
    endfunction

    // Model: asynchronous reset wipes the contents.
    always @(negedge resetn) q.delete();

    // Model: FIFO rules applied at each rising edge.
    always @(posedge clk) begin
        if (resetn) begin
            automatic bit do_pop  = (q.size() > 0) && m_tready;
            automatic bit do_push = s_tvalid && ((q.size() < DEPTH) || do_pop);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({s_tlast, s_tkeep, s_tdata});
        end
    end

    // Compare process plus delivered-beat capture.
    always @(negedge clk) begin
        automatic bit            e_valid = (q.size() != 0);
        automatic logic [DB+KW:0] e_ent  = e_valid ? q[0] : '0;
        chk("tvalid", int'(m_tvalid), int'(e_valid));
        chk("tdata",  int'(m_tdata),  int'(e_ent[DB-1:0]));
        chk("tkeep",  int'(m_tkeep),  int'(e_ent[DB +: KW]));
        chk("tlast",  int'(m_tlast),  int'(e_ent[DB+KW]));
        if (resetn && m_tvalid && m_tready) log_q.push_back({m_tlast, m_tkeep, m_tdata});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn   = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 8'h55;
        s_tkeep  = '1;
        s_tlast  = 1'b1;
        m_tready = 1'b0;

        // Reset held with tvalid high.
        repeat (5) step();
        chk("rst_tvalid", int'(m_tvalid), 0);
        chk("rst_tdata",  int'(m_tdata),  0);
        chk("rst_tkeep",  int'(m_tkeep),  0);
        chk("rst_tlast",  int'(m_tlast),  0);
        resetn   = 1'b1;
        s_tvalid = 1'b0;
        step();
        step();
        chk("post_rst_empty", int'(m_tvalid), 0);

        // Fill and overflow: 20 beats into 16 slots.
        for (int i = 0; i < 20; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = fill_d(i);
            s_tkeep  = 1'b1;
            s_tlast  = 1'b0;
            step();
            if (i == 0) begin
                chk("fill_first_valid", int'(m_tvalid), 1);
                chk("fill_first_data",  int'(m_tdata),  8'h30);
            end
        end
        s_tvalid = 1'b0;
        chk("fill_model_occ", q.size(), 16);
        chk("fill_head", int'(m_tdata), 8'h30);

        // Drain.
        log_q.delete();
        m_tready = 1'b1;
        repeat (20) step();
        chk("drain_count", log_q.size(), 16);
        for (int k = 0; k < log_q.size() && k < 16; k++)
            chk("drain_order", int'(log_q[k][DB-1:0]), int'(fill_d(k)));
        chk("drain_last", int'(log_q[15][DB-1:0]), 8'h5D);
        chk("drain_empty_valid", int'(m_tvalid), 0);
        chk("drain_empty_data",  int'(m_tdata),  0);

        // Streaming with ready held high.
        log_q.delete();
        for (int i = 1; i <= 20; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = DB'(i);
            step();
            chk("stream_valid", int'(m_tvalid), 1);
            chk("stream_data",  int'(m_tdata),  i);
            chk("stream_occ",   int'(q.size() <= 1), 1);
        end
        s_tvalid = 1'b0;
        step();
        chk("stream_end_empty", int'(m_tvalid), 0);
        chk("stream_count", log_q.size(), 20);

        // Full with simultaneous push and pop.
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = DB'(8'h80 + i);
            step();
        end
        s_tvalid = 1'b1;
        s_tdata  = 8'hAA;
        m_tready = 1'b1;
        step();
        s_tvalid = 1'b0;
        chk("full_pp_occ",  q.size(), 16);
        chk("full_pp_head", int'(m_tdata), 8'h81);
        log_q.delete();
        repeat (20) step();
        chk("full_pp_count", log_q.size(), 16);
        chk("full_pp_first", int'(log_q[0][DB-1:0]), 8'h81);
        chk("full_pp_aa",    int'(log_q[15][DB-1:0]), 8'hAA);

        // Sideband and wrap: 40 beats, draining at half rate.
        for (int i = 0; i < 40; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = DB'(8'hC0 + i);
            s_tlast  = (i % 2 == 0);
            s_tkeep  = KW'((i % 3 == 0) ? 0 : 1);
            m_tready = (i % 2 == 1);
            step();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        chk("wrap_full", int'(m_tvalid), 1);

        // Reset mid-operation loses everything immediately.
        resetn = 1'b0;
        #1;
        chk("midrst_valid", int'(m_tvalid), 0);
        chk("midrst_data",  int'(m_tdata),  0);
        step();
        resetn = 1'b1;
        m_tready = 1'b1;
        step();
        step();
        chk("midrst_after", int'(m_tvalid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
